// File: rtl/mult_n_pkg.sv
// Shared types and constants for the mult_n shift-and-add multiplier.
// The optional MULT_N_SIGNED_EN build adds two's-complement support in mult_n.
package mult_n_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_n.sv
// Sequential shift-and-add multiplier: WIDTH SHIFT cycles, result in pp with a done pulse.
// Define MULT_N_SIGNED_EN to add the sgn port and two's-complement operand handling.
module mult_n
    import mult_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MULT_N_SIGNED_EN
    input  logic               sgn,
`endif
    output logic [2*WIDTH-1:0] pp,
    output logic               done,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int CW = cnt_bits(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("mult_n: WIDTH out of range");
    end

    state_t               state, state_nx;
    logic                 init_q, init_q2, init_armed;
    logic                 start;
    logic [2*WIDTH-1:0]   mcand, acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 neg_in, neg_q;

    // init_armed stays low until init is seen low after reset, so a level
    // held through reset release cannot masquerade as a rising edge.
    assign start     = init_q & ~init_q2 & init_armed;
    assign dbg_state = state;

    always_comb begin
        a_mag  = A;
        b_mag  = B;
        neg_in = 1'b0;
`ifdef MULT_N_SIGNED_EN
        if (sgn) begin
            a_mag  = A[WIDTH-1] ? -A : A;
            b_mag  = B[WIDTH-1] ? -B : B;
            neg_in = A[WIDTH-1] ^ B[WIDTH-1];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q     <= 1'b0;
            init_q2    <= 1'b0;
            init_armed <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            pp         <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            init_q  <= init;
            init_q2 <= init_q;
            if (!init) init_armed <= 1'b1;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg_q  <= neg_in;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                end
                DONE: begin
                    pp   <= neg_q ? -acc : acc;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
